small_logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor of the fixed 8-bit small combinational logic block. It applies one of eight selectable operations (pass, invert, xor, add, and, or, accumulate, clear) to two OW-bit operands. The result passes through a 2-stage registered pipeline with valid/ready handshakes on both sides. It sits between a streaming producer and consumer in the comparison test designs, and also serves as a small accumulator.

---
 rtl/slu_pkg.sv | 21 ++
 rtl/slu_op_core.sv | 67 ++++++
 rtl/small_logic_unit_pipe.sv | 151 +++++++++++++++
 tb/tb_small_logic_unit_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slu_pkg.sv
// -----------------------------------------------------------------------------
// slu_pkg
// Shared definitions for the small logic unit pipeline: the op-code width and
// the eight operation codes carried on in_op.
// -----------------------------------------------------------------------------
package slu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS = 3'd0,   // res = a
        OP_NOT  = 3'd1,   // res = ~a
        OP_XOR  = 3'd2,   // res = a ^ b
        OP_ADD  = 3'd3,   // {carry,res} = a + b
        OP_AND  = 3'd4,   // res = a & b
        OP_OR   = 3'd5,   // res = a | b
        OP_ACC  = 3'd6,   // {carry,res} = acc + a, acc <= res
        OP_CLR  = 3'd7    // res = ACC_INIT, acc <= ACC_INIT
    } op_e;

endpackage : slu_pkg

// File: rtl/slu_op_core.sv
// -----------------------------------------------------------------------------
// slu_op_core
// Purely combinational operation core. Computes the result and carry for one
// request from its operands and the current accumulator value, and tells the
// pipeline whether (and to what) the accumulator must be updated.
//
// Ports:
//   op       in   op_e   operation select
//   a, b     in   OW     operands (b ignored by PASS/NOT/ACC/CLR)
//   acc      in   OW     current accumulator value
//   res      out  OW     operation result
//   carry    out  1      carry-out of ADD/ACC, 0 otherwise
//   acc_next out  OW     accumulator value to store when acc_we is set
//   acc_we   out  1      accumulator write enable (ACC and CLR only)
// -----------------------------------------------------------------------------
module slu_op_core
    import slu_pkg::*;
#(
    parameter int            OW       = 8,
    parameter logic [OW-1:0] ACC_INIT = '0
) (
    input  op_e           op,
    input  logic [OW-1:0] a,
    input  logic [OW-1:0] b,
    input  logic [OW-1:0] acc,
    output logic [OW-1:0] res,
    output logic          carry,
    output logic [OW-1:0] acc_next,
    output logic          acc_we
);

    logic [OW:0] sum;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        sum      = '0;
        res      = '0;
        carry    = 1'b0;
        acc_next = acc;
        acc_we   = 1'b0;
        unique case (op)
            OP_PASS: res = a;
            OP_NOT:  res = ~a;
            OP_XOR:  res = a ^ b;
            OP_ADD: begin
                sum          = {1'b0, a} + {1'b0, b};
                {carry, res} = sum;
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ACC: begin
                sum          = {1'b0, acc} + {1'b0, a};
                {carry, res} = sum;
                acc_next     = sum[OW-1:0];
                acc_we       = 1'b1;
            end
            OP_CLR: begin
                res      = ACC_INIT;
                acc_next = ACC_INIT;
                acc_we   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : slu_op_core

// File: rtl/small_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// small_logic_unit_pipe
// Two-stage registered logic/arithmetic unit with valid/ready on both sides.
// Stage 1 captures the op-core result at the accept edge (the accumulator is
// updated on that same edge so back-to-back ACC requests chain). Stage 2 holds
// the presented result and is stable while the consumer stalls.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous reset, active-high
//   in_valid   in   1    producer has a request
//   in_ready   out  1    request accepted this cycle if in_valid
//   in_op      in   3    operation code (see slu_pkg)
//   in_a/in_b  in   OW   operands
//   out_valid  out  1    result available
//   out_ready  in   1    consumer takes result this cycle
//   out_res    out  OW   result
//   out_carry  out  1    carry of ADD/ACC, else 0
//   out_zero   out  1    out_res == 0
// -----------------------------------------------------------------------------
module small_logic_unit_pipe
    import slu_pkg::*;
#(
    parameter int            OW       = 8,
    parameter logic [OW-1:0] ACC_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [OW-1:0]   in_a,
    input  logic [OW-1:0]   in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_res,
    output logic            out_carry,
    output logic            out_zero
);

    // Pipeline and accumulator state
    logic          s1_valid_q, s1_valid_d;
    logic [OW-1:0] s1_res_q,   s1_res_d;
    logic          s1_carry_q, s1_carry_d;
    logic          s2_valid_q, s2_valid_d;
    logic [OW-1:0] s2_res_q,   s2_res_d;
    logic          s2_carry_q, s2_carry_d;
    logic          s2_zero_q,  s2_zero_d;
    logic [OW-1:0] acc_q,      acc_d;

    // Op-core results
    logic [OW-1:0] core_res;
    logic          core_carry;
    logic [OW-1:0] core_acc_next;
    logic          core_acc_we;

    // Handshake
    logic s2_advance;
    logic s1_load;
    logic accept;

    slu_op_core #(
        .OW       (OW),
        .ACC_INIT (ACC_INIT)
    ) u_op_core (
        .op       (op_e'(in_op)),
        .a        (in_a),
        .b        (in_b),
        .acc      (acc_q),
        .res      (core_res),
        .carry    (core_carry),
        .acc_next (core_acc_next),
        .acc_we   (core_acc_we)
    );

    // Stage 2 can take new data when empty or being consumed; stage 1 can
    // take a request when empty or when it is moving into stage 2. in_ready
    // is therefore combinational from out_ready by design.
    assign s2_advance = !s2_valid_q || out_ready;
    assign s1_load    = !s1_valid_q || s2_advance;
    assign in_ready   = s1_load;
    assign accept     = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_res_d   = s1_res_q;
        s1_carry_d = s1_carry_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_carry_d = s2_carry_q;
        s2_zero_d  = s2_zero_q;
        acc_d      = acc_q;

        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_res_d   = core_res;
                s1_carry_d = core_carry;
            end
        end

        // A refused request (in_ready=0) must leave the accumulator untouched.
        if (accept && core_acc_we) begin
            acc_d = core_acc_next;
        end

        // When stage 1 is empty the data outputs keep their last value; only
        // the valid flag drains.
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d   = s1_res_q;
                s2_carry_d = s1_carry_q;
                s2_zero_d  = (s1_res_q == '0);
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stage-1 data registers are reset too even though their
            // valid flag already masks them; it keeps the output side fully
            // defined after reset at negligible cost for a two-entry pipeline.
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_carry_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_carry_q <= 1'b0;
            s2_zero_q  <= 1'b0;
            acc_q      <= ACC_INIT;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_carry_q <= s1_carry_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_carry_q <= s2_carry_d;
            s2_zero_q  <= s2_zero_d;
            acc_q      <= acc_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_carry = s2_carry_q;
    assign out_zero  = s2_zero_q;

endmodule : small_logic_unit_pipe

// File: tb/tb_small_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_small_logic_unit_pipe
// Self-checking bench. A transaction-level model keeps a queue of results that
// have been accepted but not yet delivered; the DUT outputs are compared to it
// on every falling edge. Directed sequences additionally check the delivered
// stream against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_small_logic_unit_pipe;

    localparam int            OW       = 8;
    localparam logic [OW-1:0] ACC_INIT = 8'h00;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op     = 3'd0;
    logic [OW-1:0] in_a      = '0;
    logic [OW-1:0] in_b      = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_res;
    logic          out_carry;
    logic          out_zero;

    always #5 clk = ~clk;

    small_logic_unit_pipe #(
        .OW       (OW),
        .ACC_INIT (ACC_INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [OW-1:0] res;
        logic          carry;
        logic          zero;
        int            k;      // index of the edge that accepted it
    } item_t;

    item_t         exp_q[$];   // accepted, not yet delivered
    item_t         dut_got[$]; // what the DUT actually handed over
    item_t         last_shown;
    logic [OW-1:0] macc;
    int            edge_cnt = 0;
    bit            live     = 1'b0;
    int            checks   = 0;
    int            errors   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour in plain arithmetic: returns {carry, res}.
    function automatic logic [OW:0] ref_result(input int op, input logic [OW-1:0] a,
                                               input logic [OW-1:0] b, input logic [OW-1:0] acc);
        case (op)
            0:       return {1'b0, a};
            1:       return {1'b0, ~a};
            2:       return {1'b0, a ^ b};
            3:       return {1'b0, a} + {1'b0, b};
            4:       return {1'b0, a & b};
            5:       return {1'b0, a | b};
            6:       return {1'b0, acc} + {1'b0, a};
            default: return {1'b0, ACC_INIT};
        endcase
    endfunction

    // Head of the queue is visible once at least one edge has passed since
    // its accept edge; the pipe holds two entries, so only a full pipe with a
    // stalled consumer refuses input.
    function automatic bit exp_valid();
        return (exp_q.size() > 0) && (edge_cnt > exp_q[0].k);
    endfunction

    function automatic bit exp_in_ready();
        return (exp_q.size() < 2) || out_ready;
    endfunction

    always @(posedge clk) begin : model_p
        logic [OW:0] r;
        bit          pop;
        bit          acc_ok;
        item_t       it;
        if (rst) begin
            exp_q.delete();
            macc       = ACC_INIT;
            last_shown = '{res: '0, carry: 1'b0, zero: 1'b0, k: 0};
            live       = 1'b1;
        end else if (live) begin
            pop    = exp_valid() && out_ready;
            acc_ok = in_valid && exp_in_ready();
            if (pop) begin
                last_shown = exp_q[0];
                void'(exp_q.pop_front());
            end
            if (acc_ok) begin
                r        = ref_result(int'(in_op), in_a, in_b, macc);
                it.res   = r[OW-1:0];
                it.carry = r[OW];
                it.zero  = (r[OW-1:0] == '0);
                it.k     = edge_cnt + 1;
                exp_q.push_back(it);
                if (in_op == 3'd6) macc = r[OW-1:0];
                else if (in_op == 3'd7) macc = ACC_INIT;
            end
        end
        edge_cnt++;
    end

    always @(negedge clk) begin : compare_p
        item_t ref_it;
        item_t got;
        if (live) begin
            check("out_valid", out_valid, exp_valid());
            check("in_ready", in_ready, exp_in_ready());
            ref_it = exp_valid() ? exp_q[0] : last_shown;
            check("out_res", out_res, ref_it.res);
            check("out_carry", out_carry, ref_it.carry);
            check("out_zero", out_zero, ref_it.zero);
            if (out_valid && out_ready) begin
                got.res   = out_res;
                got.carry = out_carry;
                got.zero  = out_zero;
                got.k     = edge_cnt;
                dut_got.push_back(got);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic send(input int op, input logic [OW-1:0] a, input logic [OW-1:0] b);
        bit done = 1'b0;
        logic [31:0] opv = op;
        in_valid = 1'b1;
        in_op    = opv[2:0];
        in_a     = a;
        in_b     = b;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        bit empty = 1'b0;
        in_valid = 1'b0;
        for (int t = 0; t < 100 && !empty; t++) begin
            tick();
            empty = (exp_q.size() == 0);
        end
        if (!empty) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_out(input string name, input int idx, input logic [OW-1:0] res,
                              input logic carry, input logic zero);
        if (idx >= dut_got.size()) begin
            check({name, "_missing"}, dut_got.size(), idx + 1);
        end else begin
            check({name, "_res"}, dut_got[idx].res, res);
            check({name, "_carry"}, dut_got[idx].carry, carry);
            check({name, "_zero"}, dut_got[idx].zero, zero);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        int e0;
        int rop;

        // ---- 1: reset state, single-op latency, logic ops back-to-back
        do_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_res", out_res, 8'h00);
        tick();
        out_ready = 1'b1;
        n0 = dut_got.size();
        send(0, 8'hA5, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_after_accept", out_valid, 1'b0);
        tick();
        @(negedge clk);
        check("lat_second_edge", out_valid, 1'b1);
        check("lat_res", out_res, 8'hA5);
        tick();
        send(1, 8'hA5, 8'h00);
        send(2, 8'hF0, 8'h3C);
        send(4, 8'hF0, 8'h3C);
        send(5, 8'hF0, 8'h3C);
        drain();
        expect_out("pass", n0 + 0, 8'hA5, 1'b0, 1'b0);
        expect_out("not",  n0 + 1, 8'h5A, 1'b0, 1'b0);
        expect_out("xor",  n0 + 2, 8'hCC, 1'b0, 1'b0);
        expect_out("and",  n0 + 3, 8'h30, 1'b0, 1'b0);
        expect_out("or",   n0 + 4, 8'hFC, 1'b0, 1'b0);

        // ---- 2: ADD with and without carry-out
        n0 = dut_got.size();
        send(3, 8'hFF, 8'h01);
        send(3, 8'h10, 8'h20);
        drain();
        expect_out("add_wrap", n0 + 0, 8'h00, 1'b1, 1'b1);
        expect_out("add_plain", n0 + 1, 8'h30, 1'b0, 1'b0);

        // ---- 3: chained ACC, CLR, ACC
        do_reset();
        n0 = dut_got.size();
        send(6, 8'h80, 8'hFF);
        send(6, 8'h80, 8'h00);
        send(6, 8'h05, 8'h00);
        send(7, 8'h00, 8'h00);
        send(6, 8'h07, 8'h00);
        drain();
        expect_out("acc1", n0 + 0, 8'h80, 1'b0, 1'b0);
        expect_out("acc2", n0 + 1, 8'h00, 1'b1, 1'b1);
        expect_out("acc3", n0 + 2, 8'h05, 1'b0, 1'b0);
        expect_out("clr",  n0 + 3, 8'h00, 1'b0, 1'b1);
        expect_out("acc4", n0 + 4, 8'h07, 1'b0, 1'b0);

        // ---- 4: backpressure fills both stages, then release
        out_ready = 1'b0;
        n0 = dut_got.size();
        send(0, 8'h11, 8'h00);
        send(0, 8'h22, 8'h00);
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 8'h33;
        @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_hold_res", out_res, 8'h11);
        tick();
        tick();
        @(negedge clk);
        check("bp_still_blocked", in_ready, 1'b0);
        check("bp_still_held", out_res, 8'h11);
        tick();
        out_ready = 1'b1;
        send(0, 8'h33, 8'h00);
        drain();
        check("bp_count", dut_got.size() - n0, 3);
        expect_out("bp0", n0 + 0, 8'h11, 1'b0, 1'b0);
        expect_out("bp1", n0 + 1, 8'h22, 1'b0, 1'b0);
        expect_out("bp2", n0 + 2, 8'h33, 1'b0, 1'b0);

        // ---- 5: random stream, gappy then continuous
        out_ready = 1'b1;
        n0 = dut_got.size();
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            rop = int'($urandom_range(0, 7));
            send(rop, OW'($urandom), OW'($urandom));
        end
        e0 = edge_cnt;
        for (int i = 0; i < 100; i++) begin
            rop = int'($urandom_range(0, 7));
            send(rop, OW'($urandom), OW'($urandom));
        end
        check("throughput_edges", edge_cnt - e0, 100);
        drain();
        check("random_count", dut_got.size() - n0, 1100);

        // ---- 6: reset mid-stream with both stages full
        out_ready = 1'b0;
        send(6, 8'h10, 8'h00);
        send(6, 8'h20, 8'h00);
        in_valid = 1'b1;
        @(negedge clk);
        check("full_out_valid", out_valid, 1'b1);
        check("full_in_ready", in_ready, 1'b0);
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_res", out_res, 8'h00);
        tick();
        n0 = dut_got.size();
        send(6, 8'h01, 8'h00);
        drain();
        check("midrst_count", dut_got.size() - n0, 1);
        expect_out("acc_after_rst", n0, 8'h01, 1'b0, 1'b0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_small_logic_unit_pipe
